// File: rtl/sevenseg_mux_n.sv
// -----------------------------------------------------------------------------
// sevenseg_mux_n
//
// Multiplexed N-digit 7-segment display driver with decimal points.
// One digit is selected per time slot and a full frame visits every digit once.
// Each slot starts with a short blank interval to prevent ghosting. A PWM window
// of programmable length follows, and the selected digit may light only inside
// that window. Inputs are copied into shadow registers once per frame, so a
// frame always shows one consistent picture. Every output is registered.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   seg_data     4*NUM_DIGITS hex nibbles, [3:0] = digit 0 (rightmost)
//   dp_in        decimal point per digit, 1 = on
//   digit_en     per-digit enable, 1 = displayed
//   brightness   PWM duty level, 0 = dimmest non-zero, all-ones = full
//   seg_cathode  {g,f,e,d,c,b,a}, polarity set by SEG_ACTIVE_LOW
//   seg_dp       decimal point, polarity set by SEG_ACTIVE_LOW
//   seg_anode    one-hot digit select, polarity set by ANODE_ACTIVE_LOW
//   frame_start  one-cycle pulse in the cycle after the shadow registers load
// -----------------------------------------------------------------------------
module sevenseg_mux_n #(
  parameter int CLK_FREQ_HZ      = 100_000_000,
  parameter int REFRESH_RATE_HZ  = 1000,
  parameter int NUM_DIGITS       = 8,
  parameter int BRIGHT_BITS      = 4,
  parameter int GHOST_CYCLES     = 16,
  parameter int ANODE_ACTIVE_LOW = 1,
  parameter int SEG_ACTIVE_LOW   = 1
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [4*NUM_DIGITS-1:0]   seg_data,
  input  logic [NUM_DIGITS-1:0]     dp_in,
  input  logic [NUM_DIGITS-1:0]     digit_en,
  input  logic [BRIGHT_BITS-1:0]    brightness,
  output logic [6:0]                seg_cathode,
  output logic                      seg_dp,
  output logic [NUM_DIGITS-1:0]     seg_anode,
  output logic                      frame_start
);

  // ---------------------------------------------------------------------------
  // Derived timing constants
  // ---------------------------------------------------------------------------
  localparam int SLOT = CLK_FREQ_HZ / (REFRESH_RATE_HZ * NUM_DIGITS);
  localparam int W    = SLOT - GHOST_CYCLES;
  localparam int CW   = (SLOT > 2) ? $clog2(SLOT) : 1;
  localparam int DW   = (NUM_DIGITS > 2) ? $clog2(NUM_DIGITS) : 1;

  localparam logic [CW-1:0]         SLOT_LAST  = CW'(SLOT - 1);
  localparam logic [DW-1:0]         DIGIT_LAST = DW'(NUM_DIGITS - 1);
  localparam logic [31:0]           GHOST_U    = 32'(GHOST_CYCLES);
  localparam logic [47:0]           W_U        = 48'(W);
  localparam logic [NUM_DIGITS-1:0] ANODE_ONE  = NUM_DIGITS'(1);

  // Off levels. The active-high internal value is XORed with these, so the same
  // constant also serves as the reset and blank level.
  localparam logic [NUM_DIGITS-1:0] ANODE_OFF = {NUM_DIGITS{1'(ANODE_ACTIVE_LOW != 0)}};
  localparam logic [6:0]            SEG_OFF   = {7{1'(SEG_ACTIVE_LOW != 0)}};
  localparam logic                  DP_OFF    = 1'(SEG_ACTIVE_LOW != 0);

  // ---------------------------------------------------------------------------
  // Elaboration-time parameter checks
  // ---------------------------------------------------------------------------
  if ((NUM_DIGITS < 2) || (NUM_DIGITS > 16)) begin : g_bad_digits
    $error("sevenseg_mux_n: NUM_DIGITS must be in 2..16");
  end

  if (W < (1 << BRIGHT_BITS)) begin : g_bad_window
    $error("sevenseg_mux_n: slot too short for GHOST_CYCLES plus 2**BRIGHT_BITS PWM steps");
  end

  if ((ANODE_ACTIVE_LOW != 0 && ANODE_ACTIVE_LOW != 1) ||
      (SEG_ACTIVE_LOW != 0 && SEG_ACTIVE_LOW != 1)) begin : g_bad_polarity
    $error("sevenseg_mux_n: polarity parameters must be 0 or 1");
  end

  // ---------------------------------------------------------------------------
  // Hex nibble to active-high segment pattern {g,f,e,d,c,b,a}
  // ---------------------------------------------------------------------------
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] seg;
    case (nib)
      4'h0:    seg = 7'b0111111;
      4'h1:    seg = 7'b0000110;
      4'h2:    seg = 7'b1011011;
      4'h3:    seg = 7'b1001111;
      4'h4:    seg = 7'b1100110;
      4'h5:    seg = 7'b1101101;
      4'h6:    seg = 7'b1111101;
      4'h7:    seg = 7'b0000111;
      4'h8:    seg = 7'b1111111;
      4'h9:    seg = 7'b1101111;
      4'hA:    seg = 7'b1110111;
      4'hB:    seg = 7'b1111100;
      4'hC:    seg = 7'b0111001;
      4'hD:    seg = 7'b1011110;
      4'hE:    seg = 7'b1111001;
      4'hF:    seg = 7'b1110001;
      default: seg = 7'b0000000;
    endcase
    return seg;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CW-1:0]           slot_cnt_q,     slot_cnt_d;
  logic [DW-1:0]           digit_sel_q,    digit_sel_d;
  logic                    load_pending_q;
  logic [4*NUM_DIGITS-1:0] sh_data_q,      sh_data_d;
  logic [NUM_DIGITS-1:0]   sh_dp_q,        sh_dp_d;
  logic [NUM_DIGITS-1:0]   sh_en_q,        sh_en_d;
  logic [CW-1:0]           on_len_q,       on_len_d;
  logic                    frame_start_q,  frame_start_d;
  logic [NUM_DIGITS-1:0]   anode_q,        anode_d;
  logic [6:0]              cathode_q,      cathode_d;
  logic                    dp_q,           dp_d;

  logic                    slot_wrap_s;
  logic                    frame_load_s;
  logic [47:0]             on_len_prod_s;
  logic [47:0]             on_len_calc_s;
  logic [31:0]             slot_ext_s;
  logic                    in_window_s;
  logic                    lit_s;
  logic [3:0]              nib_s;

  // Slot wrap and frame boundary detection
  always_comb begin
    slot_wrap_s  = (slot_cnt_q == SLOT_LAST);
    frame_load_s = load_pending_q | (slot_wrap_s & (digit_sel_q == DIGIT_LAST));
  end

  // Slot and digit counters. They hold during the forced load after reset, so
  // the first frame_start is followed by a complete frame that starts at digit 0.
  always_comb begin
    slot_cnt_d  = slot_cnt_q;
    digit_sel_d = digit_sel_q;
    if (load_pending_q) begin
      slot_cnt_d  = slot_cnt_q;
      digit_sel_d = digit_sel_q;
    end else if (slot_wrap_s) begin
      slot_cnt_d = {CW{1'b0}};
      if (digit_sel_q == DIGIT_LAST) begin
        digit_sel_d = {DW{1'b0}};
      end else begin
        digit_sel_d = digit_sel_q + DW'(1);
      end
    end else begin
      slot_cnt_d = slot_cnt_q + CW'(1);
    end
  end

  // Shadow capture and PWM window length. The brightness is kept only as the
  // derived on_len, because that is the only form the display path uses.
  always_comb begin
    on_len_prod_s = W_U * (48'(brightness) + 48'd1);
    on_len_calc_s = on_len_prod_s >> BRIGHT_BITS;
    sh_data_d     = sh_data_q;
    sh_dp_d       = sh_dp_q;
    sh_en_d       = sh_en_q;
    on_len_d      = on_len_q;
    frame_start_d = frame_load_s;
    if (frame_load_s) begin
      sh_data_d = seg_data;
      sh_dp_d   = dp_in;
      sh_en_d   = digit_en;
      on_len_d  = CW'(on_len_calc_s);
    end else begin
      sh_data_d = sh_data_q;
      sh_dp_d   = sh_dp_q;
      sh_en_d   = sh_en_q;
      on_len_d  = on_len_q;
    end
  end

  // Lit decision and output pattern, computed from the current counter state
  always_comb begin
    slot_ext_s  = 32'(slot_cnt_q);
    in_window_s = (slot_ext_s >= GHOST_U) && (slot_ext_s < (GHOST_U + 32'(on_len_q)));
    lit_s       = sh_en_q[digit_sel_q] & in_window_s;
    nib_s       = sh_data_q[{digit_sel_q, 2'b00} +: 4];
    if (lit_s) begin
      anode_d   = (ANODE_ONE << digit_sel_q) ^ ANODE_OFF;
      cathode_d = hex7(nib_s) ^ SEG_OFF;
      dp_d      = sh_dp_q[digit_sel_q] ^ DP_OFF;
    end else begin
      anode_d   = ANODE_OFF;
      cathode_d = SEG_OFF;
      dp_d      = DP_OFF;
    end
  end

  // All state and output registers. Reset drives the outputs straight to their
  // off levels without waiting for a clock edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_cnt_q     <= {CW{1'b0}};
      digit_sel_q    <= {DW{1'b0}};
      load_pending_q <= 1'b1;
      sh_data_q      <= {(4*NUM_DIGITS){1'b0}};
      sh_dp_q        <= {NUM_DIGITS{1'b0}};
      sh_en_q        <= {NUM_DIGITS{1'b0}};
      on_len_q       <= {CW{1'b0}};
      frame_start_q  <= 1'b0;
      anode_q        <= ANODE_OFF;
      cathode_q      <= SEG_OFF;
      dp_q           <= DP_OFF;
    end else begin
      slot_cnt_q     <= slot_cnt_d;
      digit_sel_q    <= digit_sel_d;
      load_pending_q <= 1'b0;
      sh_data_q      <= sh_data_d;
      sh_dp_q        <= sh_dp_d;
      sh_en_q        <= sh_en_d;
      on_len_q       <= on_len_d;
      frame_start_q  <= frame_start_d;
      anode_q        <= anode_d;
      cathode_q      <= cathode_d;
      dp_q           <= dp_d;
    end
  end

  assign seg_anode   = anode_q;
  assign seg_cathode = cathode_q;
  assign seg_dp      = dp_q;
  assign frame_start = frame_start_q;

endmodule

// File: tb/tb_sevenseg_mux_n.sv
// -----------------------------------------------------------------------------
// Directed testbench for sevenseg_mux_n.
// Two instances share all inputs: one with active-low outputs and one with
// active-high outputs. The active-high outputs are checked against the
// bitwise inverse of the active-low expectations. frame_start is not inverted.
// Timing: SLOT = 3200/(100*4) = 8, W = 6, GHOST = 2.
// on_len = (6*(b+1))>>2, giving 1, 3, 4, 6 for b = 0..3.
// -----------------------------------------------------------------------------
module tb_sevenseg_mux_n;

  localparam int NUM_DIGITS = 4;

  // Active-high segment patterns for hex 0..F
  localparam logic [6:0] SEG_TBL [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };
  localparam int ONLEN_TBL [4] = '{1, 3, 4, 6};

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] seg_data;
  logic [3:0]  dp_in;
  logic [3:0]  digit_en;
  logic [1:0]  brightness;

  logic [6:0]  cat_lo, cat_hi;
  logic        dp_lo, dp_hi;
  logic [3:0]  an_lo, an_hi;
  logic        fs_lo, fs_hi;

  // Shadow contents the current frame is expected to show
  logic [15:0] cur_data;
  logic [3:0]  cur_en;
  logic [3:0]  cur_dp;
  logic [1:0]  cur_bright;

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  sevenseg_mux_n #(
    .CLK_FREQ_HZ(3200), .REFRESH_RATE_HZ(100), .NUM_DIGITS(NUM_DIGITS),
    .BRIGHT_BITS(2), .GHOST_CYCLES(2), .ANODE_ACTIVE_LOW(1), .SEG_ACTIVE_LOW(1)
  ) dut_lo (
    .clk(clk), .rst_n(rst_n), .seg_data(seg_data), .dp_in(dp_in),
    .digit_en(digit_en), .brightness(brightness), .seg_cathode(cat_lo),
    .seg_dp(dp_lo), .seg_anode(an_lo), .frame_start(fs_lo)
  );

  sevenseg_mux_n #(
    .CLK_FREQ_HZ(3200), .REFRESH_RATE_HZ(100), .NUM_DIGITS(NUM_DIGITS),
    .BRIGHT_BITS(2), .GHOST_CYCLES(2), .ANODE_ACTIVE_LOW(0), .SEG_ACTIVE_LOW(0)
  ) dut_hi (
    .clk(clk), .rst_n(rst_n), .seg_data(seg_data), .dp_in(dp_in),
    .digit_en(digit_en), .brightness(brightness), .seg_cathode(cat_hi),
    .seg_dp(dp_hi), .seg_anode(an_hi), .frame_start(fs_hi)
  );

  // Expected values are given at active-low polarity
  task automatic check_outputs(input string tag, input logic [3:0] ea,
                               input logic [6:0] ec, input logic ed, input logic efs);
    tests_run++;
    assert ({an_lo, cat_lo, dp_lo, fs_lo} === {ea, ec, ed, efs})
    else begin
      tests_failed++;
      $error("FAIL %s low-pol: anode=%b cath=%b dp=%b fs=%b, expected anode=%b cath=%b dp=%b fs=%b",
             tag, an_lo, cat_lo, dp_lo, fs_lo, ea, ec, ed, efs);
    end
    tests_run++;
    assert ({an_hi, cat_hi, dp_hi, fs_hi} === {~ea, ~ec, ~ed, efs})
    else begin
      tests_failed++;
      $error("FAIL %s high-pol: anode=%b cath=%b dp=%b fs=%b, expected anode=%b cath=%b dp=%b fs=%b",
             tag, an_hi, cat_hi, dp_hi, fs_hi, ~ea, ~ec, ~ed, efs);
    end
  endtask

  // Checks n_cyc consecutive samples of one frame, starting at digit 0 slot 0.
  // New inputs are applied after sample chg_at (-1 = none). They must appear
  // only in the next frame.
  task automatic run_frame(input string tag, input int n_cyc, input int chg_at,
                           input logic [15:0] nd, input logic [3:0] nen,
                           input logic [3:0] ndp, input logic [1:0] nb);
    int         slot;
    int         d;
    logic       lit;
    logic [3:0] nib;
    logic [3:0] ea;
    logic [6:0] ec;
    logic       ed;
    for (int m = 0; m < n_cyc; m++) begin
      @(negedge clk);
      slot = m % 8;
      d    = m / 8;
      nib  = cur_data[d*4 +: 4];
      lit  = cur_en[d] && (slot >= 2) && (slot < 2 + ONLEN_TBL[cur_bright]);
      ea   = lit ? ~(4'b0001 << d) : 4'b1111;
      ec   = lit ? ~SEG_TBL[nib] : 7'b1111111;
      ed   = lit ? ~cur_dp[d] : 1'b1;
      check_outputs($sformatf("%s m=%0d", tag, m), ea, ec, ed, (m == 31));
      if (m == chg_at) begin
        seg_data   = nd;
        digit_en   = nen;
        dp_in      = ndp;
        brightness = nb;
      end
    end
    if (n_cyc == 32 && chg_at >= 0 && chg_at <= 30) begin
      cur_data   = nd;
      cur_en     = nen;
      cur_dp     = ndp;
      cur_bright = nb;
    end
  endtask

  initial begin
    rst_n      = 1'b0;
    seg_data   = 16'h12AF;
    dp_in      = 4'b0000;
    digit_en   = 4'hF;
    brightness = 2'd3;

    // Reset levels
    repeat (3) @(negedge clk);
    check_outputs("reset_held", 4'b1111, 7'h7F, 1'b1, 1'b0);

    // Release; the forced load gives frame_start after the first edge
    rst_n      = 1'b1;
    cur_data   = 16'h12AF;
    cur_en     = 4'hF;
    cur_dp     = 4'b0000;
    cur_bright = 2'd3;
    @(negedge clk);
    check_outputs("first_load", 4'b1111, 7'h7F, 1'b1, 1'b1);

    // Full brightness, F A 2 1, then dim to b=0
    run_frame("bright3", 32, 5, 16'h12AF, 4'hF, 4'b0000, 2'd0);
    // One lit cycle per slot; then b=1
    run_frame("bright0", 32, 5, 16'h12AF, 4'hF, 4'b0000, 2'd1);
    // Three lit cycles per slot; then disable digit 2 and set dp on digit 0
    run_frame("bright1", 32, 5, 16'h1234, 4'b1011, 4'b0001, 2'd3);
    // Digit 2 stays dark for its whole slot; re-enable all digits
    run_frame("en_dp", 32, 5, 16'h1234, 4'hF, 4'b0001, 2'd3);
    // Data changes to BEEF during digit 1; this frame must still show 1234
    run_frame("no_tear", 32, 10, 16'hBEEF, 4'hF, 4'b0001, 2'd3);
    // BEEF appears; stop partway into digit 1 while it is lit
    run_frame("beef", 12, -1, 16'hBEEF, 4'hF, 4'b0001, 2'd3);

    // Asynchronous reset between clock edges
    #2;
    rst_n = 1'b0;
    #1;
    check_outputs("async_reset", 4'b1111, 7'h7F, 1'b1, 1'b0);
    @(negedge clk);
    check_outputs("async_reset_hold", 4'b1111, 7'h7F, 1'b1, 1'b0);
    rst_n = 1'b1;
    @(negedge clk);
    check_outputs("reload", 4'b1111, 7'h7F, 1'b1, 1'b1);
    run_frame("after_reset", 32, -1, 16'hBEEF, 4'hF, 4'b0001, 2'd3);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  // Bound on the total run time
  initial begin
    #100000;
    $display("FAIL timeout: simulation did not finish, tests_run=%0d", tests_run);
    $fatal(1, "timeout");
  end

endmodule
